// File: rtl/pxs_sync_gen_pkg.sv
// Shared PixelStream definitions: stream layout, default 640x480@60 timing, colours.
// Field macros PXS_HS/VS/XC/YC/ACTIVE/RGB slice a 26-bit RGBStr word.
`ifndef PXS_SYNC_GEN_PKG_SV
`define PXS_SYNC_GEN_PKG_SV

`define PXS_HS(w)     w[25]
`define PXS_VS(w)     w[24]
`define PXS_XC(w)     w[23:14]
`define PXS_YC(w)     w[13:4]
`define PXS_ACTIVE(w) w[3]
`define PXS_RGB(w)    w[2:0]

package pxs_sync_gen_pkg;

  localparam int unsigned PXS_W     = 26;
  localparam int unsigned PXS_CNT_W = 10;

  localparam int unsigned PXS_H_ACTIVE_DEF = 640;
  localparam int unsigned PXS_H_FP_DEF     = 16;
  localparam int unsigned PXS_H_SYNC_DEF   = 96;
  localparam int unsigned PXS_H_BP_DEF     = 48;
  localparam int unsigned PXS_V_ACTIVE_DEF = 480;
  localparam int unsigned PXS_V_FP_DEF     = 10;
  localparam int unsigned PXS_V_SYNC_DEF   = 2;
  localparam int unsigned PXS_V_BP_DEF     = 33;

  typedef enum logic [2:0] {
    PXS_BLACK = 3'b000,
    PXS_BLUE  = 3'b001,
    PXS_GREEN = 3'b010,
    PXS_PINK  = 3'b101,
    PXS_WHITE = 3'b111
  } pxs_color_e;

  typedef struct packed {
    logic                 hs;
    logic                 vs;
    logic [PXS_CNT_W-1:0] xc;
    logic [PXS_CNT_W-1:0] yc;
    logic                 active;
    logic [2:0]           rgb;
  } pxs_word_t;

  function automatic pxs_word_t pxs_idle_word(input logic sync_pol);
    pxs_word_t w;
    w        = '0;
    w.hs     = ~sync_pol;
    w.vs     = ~sync_pol;
    return w;
  endfunction

endpackage

`endif

// File: rtl/pxs_sync_gen_if.sv
// PixelStream source-side bundle: pixel enable in, stream word and pulses out.
interface pxs_sync_gen_if;
  import pxs_sync_gen_pkg::*;

  logic             en;
  logic [PXS_W-1:0] RGBStr_o;
  logic             frame_start;
  logic             line_start;

  modport master (input en, output RGBStr_o, frame_start, line_start);
  modport slave  (output en, input RGBStr_o, frame_start, line_start);
endinterface

// File: rtl/pxs_timing_cnt.sv
// Parametric wrap-around timing counter with active and sync range flags.
module pxs_timing_cnt
  import pxs_sync_gen_pkg::*;
#(
  parameter int unsigned ACTIVE     = PXS_H_ACTIVE_DEF,
  parameter int unsigned SYNC_START = PXS_H_ACTIVE_DEF + PXS_H_FP_DEF,
  parameter int unsigned SYNC_END   = PXS_H_ACTIVE_DEF + PXS_H_FP_DEF + PXS_H_SYNC_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc,
  input  logic [PXS_CNT_W-1:0] total,
  output logic [PXS_CNT_W-1:0] count,
  output logic                 wrap,
  output logic                 in_sync,
  output logic                 in_active
);

  localparam logic [PXS_CNT_W:0] ACT_L = (PXS_CNT_W+1)'(ACTIVE);
  localparam logic [PXS_CNT_W:0] SS_L  = (PXS_CNT_W+1)'(SYNC_START);
  localparam logic [PXS_CNT_W:0] SE_L  = (PXS_CNT_W+1)'(SYNC_END);

  logic [PXS_CNT_W:0] count_x;

  // a total of 1024 truncates to 0, and 0-1 still lands on 1023
  assign wrap      = (count == total - PXS_CNT_W'(1));
  assign count_x   = {1'b0, count};
  assign in_active = (count_x < ACT_L);
  assign in_sync   = (count_x >= SS_L) && (count_x < SE_L);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= '0;
    else if (inc)
      count <= wrap ? '0 : count + PXS_CNT_W'(1);
  end

endmodule

// File: rtl/pxs_sync_gen.sv
// PixelStream source: free-running H/V timing into a registered RGBStr word.
// Optional PXS_SYNC_TESTPATTERN_EN replaces the background with 8 vertical bars.
module pxs_sync_gen
  import pxs_sync_gen_pkg::*;
#(
  parameter int unsigned H_ACTIVE = PXS_H_ACTIVE_DEF,
  parameter int unsigned H_FP     = PXS_H_FP_DEF,
  parameter int unsigned H_SYNC   = PXS_H_SYNC_DEF,
  parameter int unsigned H_BP     = PXS_H_BP_DEF,
  parameter int unsigned V_ACTIVE = PXS_V_ACTIVE_DEF,
  parameter int unsigned V_FP     = PXS_V_FP_DEF,
  parameter int unsigned V_SYNC   = PXS_V_SYNC_DEF,
  parameter int unsigned V_BP     = PXS_V_BP_DEF,
  parameter logic        SYNC_POL = 1'b0,
  parameter logic [2:0]  BG_COLOR = PXS_BLUE
) (
  input  logic           px_clk,
  input  logic           rst,
  pxs_sync_gen_if.master pxs
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  logic [PXS_CNT_W-1:0] hcnt, vcnt;
  logic                 h_wrap, v_wrap;
  logic                 h_sync, v_sync;
  logic                 h_act, v_act;
  logic                 at_line_q, at_origin_q;
  logic [2:0]           act_rgb;
  pxs_word_t            word_d, word_q;
  logic                 frame_start_q, line_start_q;

  pxs_timing_cnt #(
    .ACTIVE     (H_ACTIVE),
    .SYNC_START (H_ACTIVE + H_FP),
    .SYNC_END   (H_ACTIVE + H_FP + H_SYNC)
  ) u_hcnt (
    .clk       (px_clk),
    .rst       (rst),
    .inc       (pxs.en),
    .total     (PXS_CNT_W'(H_TOTAL)),
    .count     (hcnt),
    .wrap      (h_wrap),
    .in_sync   (h_sync),
    .in_active (h_act)
  );

  pxs_timing_cnt #(
    .ACTIVE     (V_ACTIVE),
    .SYNC_START (V_ACTIVE + V_FP),
    .SYNC_END   (V_ACTIVE + V_FP + V_SYNC)
  ) u_vcnt (
    .clk       (px_clk),
    .rst       (rst),
    .inc       (pxs.en & h_wrap),
    .total     (PXS_CNT_W'(V_TOTAL)),
    .count     (vcnt),
    .wrap      (v_wrap),
    .in_sync   (v_sync),
    .in_active (v_act)
  );

`ifdef PXS_SYNC_TESTPATTERN_EN
  logic [2:0] bar;

  // bar = floor(hcnt*8/H_ACTIVE) via hcnt*8 >= k*H_ACTIVE, no divider
  always_comb begin
    bar = '0;
    for (int unsigned k = 1; k < 8; k++)
      if ({hcnt, 3'b000} >= (PXS_CNT_W+3)'(k * H_ACTIVE))
        bar = 3'(k);
  end

  assign act_rgb = 3'd7 - bar;
`else
  assign act_rgb = BG_COLOR;
`endif

  always_comb begin
    word_d        = '0;
    word_d.hs     = h_sync ? SYNC_POL : ~SYNC_POL;
    word_d.vs     = v_sync ? SYNC_POL : ~SYNC_POL;
    word_d.xc     = hcnt;
    word_d.yc     = vcnt;
    word_d.active = h_act & v_act;
    word_d.rgb    = (h_act & v_act) ? act_rgb : PXS_BLACK;
  end

  // Flags remember that the counters now sit at XC=0 / (0,0), decoded from
  // the wrap of the previous enabled step instead of comparing the counts.
  always_ff @(posedge px_clk or posedge rst) begin
    if (rst) begin
      at_line_q   <= 1'b1;
      at_origin_q <= 1'b1;
    end else if (pxs.en) begin
      at_line_q   <= h_wrap;
      at_origin_q <= h_wrap & v_wrap;
    end
  end

  always_ff @(posedge px_clk or posedge rst) begin
    if (rst) begin
      word_q        <= pxs_idle_word(SYNC_POL);
      frame_start_q <= 1'b0;
      line_start_q  <= 1'b0;
    end else begin
      frame_start_q <= pxs.en & at_origin_q;
      line_start_q  <= pxs.en & at_line_q;
      if (pxs.en)
        word_q <= word_d;
    end
  end

  assign pxs.RGBStr_o    = word_q;
  assign pxs.frame_start = frame_start_q;
  assign pxs.line_start  = line_start_q;

endmodule

// File: doc/pxs_sync_gen.md
Name: pxs_sync_gen

Overview:
- Source end of the PixelStream bus: generates the 26-bit RGBStr stream that downstream Pxs stages (overlays, filters, cursor) consume and the VGA output stage drains.
- Runs free-running horizontal/vertical counters and derives HS, VS, Active, XC, YC and a background RGB value.
- Sits at the head of every Pxs pipeline, clocked by the pixel clock.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 1'b0, asserted level of HS/VS (0 = active-low)
- BG_COLOR, 3'b001, RGB value driven during active video

Ports:
- px_clk  in  1  pixel clock
- rst  in  1  asynchronous, active-high reset
- en  in  1  pixel enable; counters and outputs advance only when 1
- RGBStr_o  out  26  PixelStream word: [25] HS, [24] VS, [23:14] XC, [13:4] YC, [3] Active, [2:0] RGB; accessed through the shared field macros
- frame_start  out  1  one-cycle pulse coinciding with the output word for pixel (0,0)
- line_start  out  1  one-cycle pulse coinciding with the output word for XC=0 of every line

Behaviour:
- One clock, px_clk; reset is asynchronous and active-high, port rst.
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL likewise (525). Both counters are 10 bits; totals must be ≤ 1024.
- hcnt increments when en=1. At H_TOTAL-1 it wraps to 0 and vcnt increments. vcnt wraps to 0 at V_TOTAL-1 when hcnt wraps.
- All outputs are registered: a word reflects the counter values of the previous enabled cycle, so latency is 1 from counter to output.
- XC = hcnt, YC = vcnt, unclipped; blanking coordinates are visible downstream.
- Active = (hcnt < H_ACTIVE) && (vcnt < V_ACTIVE).
- HS = SYNC_POL when H_ACTIVE+H_FP ≤ hcnt < H_ACTIVE+H_FP+H_SYNC, else ~SYNC_POL (defaults: 656..751).
- VS = SYNC_POL when V_ACTIVE+V_FP ≤ vcnt < V_ACTIVE+V_FP+V_SYNC, else ~SYNC_POL (defaults: 490..491). VS changes together with the HS-line boundary, i.e. on hcnt=0.
- RGB = BG_COLOR when Active, else 3'b000. Blanking RGB is always black.
- frame_start = 1 for the word with hcnt=0 and vcnt=0. line_start = 1 for every word with hcnt=0.
- en=0: counters hold, RGBStr_o holds its last value, frame_start and line_start go to 0. On re-enable the sequence resumes with no pixel skipped.
- Reset, including mid-frame: hcnt=vcnt=0 immediately. RGBStr_o is HS=VS=~SYNC_POL, XC=0, YC=0, Active=0, RGB=0; frame_start=line_start=0. The first enabled edge after release emits the word for (0,0) with frame_start=1.

Optional Feature:
- Macro PXS_SYNC_TESTPATTERN_EN.
- Defined: during Active, RGB = 8 vertical colour bars; bar index = XC*8/H_ACTIVE, implemented with constant-compare thresholds and no divider. Bar k drives RGB = 3'(7-k), so white is at the left and black at the right. Blanking stays 0.
- Undefined: RGB = BG_COLOR during Active, as above. No bar logic is synthesised.

Decomposition:
- Add to the shared Pxs header/package:
  - stream field macros (HS, VS, XC, YC, Active, RGB) and stream width 26
  - default 640x480@60 timing constants
  - colour constants: black, blue, green, white, pink
- One natural sub-module: pxs_timing_cnt, a single parametric counter instantiated twice (horizontal and vertical). It has inputs inc/total and outputs count, wrap, and in_sync/in_active range flags.

Test Plan:
- Reset release, en=1 → first word XC=0, YC=0, Active=1, RGB=3'b001, HS=VS=1, frame_start=1. 800 cycles later line_start=1 with YC=1.
- Run one line → Active high for exactly 640 words. HS low exactly for XC 656..751. Word at XC=799 is followed by XC=0.
- Run a full frame (420000 cycles) → VS low exactly on YC 490..491. frame_start period is 420000. YC wraps 524→0.
- Toggle en low for 5 cycles at XC=100 → output frozen at XC=100 with pulses low. After re-enable the next word is XC=101.
- Assert rst asynchronously at XC=300, YC=200 → outputs reach reset values before the next edge. After release the stream restarts at (0,0) with frame_start=1.
- With PXS_SYNC_TESTPATTERN_EN defined → RGB = 7 at XC=0, 6 at XC=80, 0 at XC=639, 0 at XC=640.
